// File: rtl/exec_sequencer.sv
// exec_sequencer: run/step/halt controller for the 16-bit MIPS core.
// Owns the program counter and the 2-bit microcode phase. Both advance only on
// qualified rate-divider ticks, so the whole core runs from a single clock.
module exec_sequencer #(
    parameter int unsigned     AW         = 10,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          Clear,
    input  logic          tick,
    input  logic          run,
    input  logic          step,
    input  logic          back,
    input  logic          jflag,
    input  logic [AW-1:0] jaddr,
    input  logic          enloop,
    input  logic          halt_instr,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    output logic [AW-1:0] pc,
    output logic [1:0]    phase,
    output logic          phase_adv,
    output logic          instr_done,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [1:0]    r_phase;
    logic          r_done;
    logic          r_skip_bp;   // set while stepping off a breakpoint

    state_t        w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic [1:0]    w_phase_nxt;
    logic          w_done_nxt;
    logic          w_skip_nxt;

    logic          w_adv;
    logic          w_end;
    logic [AW-1:0] w_pc_ret;
    logic          w_stop;
    logic          w_bp_hit;

    assign w_adv    = tick & ((r_state == ST_RUN) | (r_state == ST_STEP));
    assign w_end    = w_adv & (r_phase == 2'd3);
    assign w_bp_hit = bp_en & (w_pc_ret == bp_addr) & ~r_skip_bp;

    // PC target and halt decision for the instruction now retiring
    always_comb begin
        w_stop   = 1'b0;
        w_pc_ret = r_pc + AW'(1);
        if (halt_instr) begin
            w_stop   = 1'b1;
            w_pc_ret = r_pc;
        end else if (jflag) begin
            w_pc_ret = jaddr;
        end else if (&r_pc) begin
            if (enloop) begin
                w_pc_ret = '0;
            end else begin
                w_stop   = 1'b1;
                w_pc_ret = r_pc;
            end
        end
    end

    // Next-state, PC and phase selection
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        w_skip_nxt  = r_skip_bp;
        unique case (r_state)
            ST_HALT: begin
                if (back) begin
                    if (r_pc != '0) begin
                        w_pc_nxt = r_pc - AW'(1);
                    end
                    w_phase_nxt = 2'd0;
                end else if (step) begin
                    w_state_nxt = ST_STEP;
                    w_skip_nxt  = 1'b0;
                end else if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_adv) begin
                    w_phase_nxt = r_phase + 2'd1;
                end
                if (w_end) begin
                    w_done_nxt = 1'b1;
                    w_pc_nxt   = w_pc_ret;
                    w_skip_nxt = 1'b0;
                    if (w_stop) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_bp_hit) begin
                        w_state_nxt = ST_BREAK;
                    end else if ((r_state == ST_STEP) || !run) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_BREAK: begin
                if (step) begin
                    w_state_nxt = ST_STEP;
                    w_skip_nxt  = 1'b1;
                end else if (!run) begin
                    w_state_nxt = ST_HALT;
                end
            end
        endcase
    end

    // State, PC, phase and completion-pulse registers
    always_ff @(posedge clk) begin
        if (Clear) begin
            r_state   <= ST_HALT;
            r_pc      <= RESET_ADDR;
            r_phase   <= 2'd0;
            r_done    <= 1'b0;
            r_skip_bp <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_phase   <= w_phase_nxt;
            r_done    <= w_done_nxt;
            r_skip_bp <= w_skip_nxt;
        end
    end

    assign pc         = r_pc;
    assign phase      = r_phase;
    assign phase_adv  = w_adv;
    assign instr_done = r_done;
    assign state      = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_exec_sequencer;

    localparam int AW    = 10;
    localparam int S_HLT = 0;
    localparam int S_RUN = 1;
    localparam int S_STP = 2;
    localparam int S_BRK = 3;

    logic          clk = 1'b0;
    logic          Clear, tick, run, step, back, jflag, enloop, halt_instr, bp_en;
    logic [AW-1:0] jaddr, bp_addr;
    logic [AW-1:0] pc;
    logic [1:0]    phase;
    logic          phase_adv, instr_done;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    exec_sequencer #(.AW(AW), .RESET_ADDR('0)) dut (
        .clk        (clk),
        .Clear      (Clear),
        .tick       (tick),
        .run        (run),
        .step       (step),
        .back       (back),
        .jflag      (jflag),
        .jaddr      (jaddr),
        .enloop     (enloop),
        .halt_instr (halt_instr),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .phase      (phase),
        .phase_adv  (phase_adv),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one instruction = four qualified ticks; retirement
    // applies the PC rules, then decides whether execution continues.
    logic [AW-1:0] m_pc;
    int            m_phase;
    int            m_state;
    bit            m_done;
    bit            m_leaving_bp;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        bit stop;
        if (Clear) begin
            m_pc = '0; m_phase = 0; m_state = S_HLT; m_done = 0;
            m_leaving_bp = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 0;
            if (m_state == S_HLT) begin
                if (back) begin
                    if (m_pc != 0) m_pc = m_pc - 1'b1;
                    m_phase = 0;
                end else if (step) begin
                    m_state = S_STP; m_leaving_bp = 0;
                end else if (run) begin
                    m_state = S_RUN;
                end
            end else if (m_state == S_BRK) begin
                if (step) begin
                    m_state = S_STP; m_leaving_bp = 1;
                end else if (!run) begin
                    m_state = S_HLT;
                end
            end else if (tick) begin
                if (m_phase < 3) begin
                    m_phase++;
                end else begin
                    m_phase = 0;
                    m_done  = 1;
                    stop    = 0;
                    if (halt_instr)                stop = 1;
                    else if (jflag)                m_pc = jaddr;
                    else if (m_pc == {AW{1'b1}})   begin if (enloop) m_pc = '0; else stop = 1; end
                    else                           m_pc = m_pc + 1'b1;
                    if (stop)                                              m_state = S_HLT;
                    else if (bp_en && m_pc == bp_addr && !m_leaving_bp)    m_state = S_BRK;
                    else if (m_state == S_STP || !run)                     m_state = S_HLT;
                    m_leaving_bp = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_pc",        int'(pc),         int'(m_pc));
            chk("cyc_phase",     int'(phase),      m_phase);
            chk("cyc_state",     int'(state),      m_state);
            chk("cyc_done",      int'(instr_done), int'(m_done));
            chk("cyc_phase_adv", int'(phase_adv),
                int'(tick && (m_state == S_RUN || m_state == S_STP)));
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) clk1();
    endtask

    initial begin
        Clear = 1; tick = 0; run = 0; step = 0; back = 0; jflag = 0;
        jaddr = '0; enloop = 0; halt_instr = 0; bp_en = 0; bp_addr = '0;
        cyc(2);
        Clear = 0;
        @(negedge clk);
        chk("reset_pc", int'(pc), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_state", int'(state), S_HLT);
        chk("reset_done", int'(instr_done), 0);

        // Free run at max rate
        run = 1; tick = 1;
        clk1();
        @(negedge clk);
        chk("run_entry_state", int'(state), S_RUN);
        chk("run_entry_phase", int'(phase), 0);
        cyc(12);
        @(negedge clk);
        chk("run12_pc", int'(pc), 3);
        chk("run12_phase", int'(phase), 0);
        chk("run12_done", int'(instr_done), 1);

        // jflag only during phase 1: ignored
        clk1();
        jflag = 1; jaddr = 10'h155;
        clk1();
        jflag = 0;
        cyc(2);
        @(negedge clk);
        chk("jflag_ph1_pc", int'(pc), 4);

        // jflag at end of instruction
        cyc(3);
        jflag = 1; jaddr = 10'h155;
        clk1();
        jflag = 0;
        @(negedge clk);
        chk("jump_pc", int'(pc), 'h155);
        chk("jump_phase", int'(phase), 0);
        chk("jump_done", int'(instr_done), 1);

        // Loop-around with enloop=1
        cyc(3);
        jflag = 1; jaddr = 10'h3FF;
        clk1();
        jflag = 0; enloop = 1;
        cyc(4);
        @(negedge clk);
        chk("wrap_pc", int'(pc), 0);
        chk("wrap_state", int'(state), S_RUN);

        // Saturation halt with enloop=0
        cyc(3);
        jflag = 1; jaddr = 10'h3FF;
        clk1();
        jflag = 0; enloop = 0;
        cyc(4);
        run = 0;
        @(negedge clk);
        chk("sat_pc", int'(pc), 'h3FF);
        chk("sat_state", int'(state), S_HLT);

        // Breakpoint at 5, then step off it
        Clear = 1;
        clk1();
        Clear = 0; bp_en = 1; bp_addr = 10'd5; run = 1;
        cyc(21);
        @(negedge clk);
        chk("bp_state", int'(state), S_BRK);
        chk("bp_pc", int'(pc), 5);
        step = 1;
        clk1();
        step = 0;
        cyc(4);
        run = 0; bp_en = 0;
        @(negedge clk);
        chk("bpstep_pc", int'(pc), 6);
        chk("bpstep_state", int'(state), S_HLT);

        // back wins over step, then back down to zero and no underflow
        back = 1; step = 1;
        clk1();
        back = 0; step = 0;
        @(negedge clk);
        chk("backstep_pc", int'(pc), 5);
        chk("backstep_state", int'(state), S_HLT);
        for (int k = 0; k < 6; k++) begin
            back = 1;
            clk1();
            back = 0;
            @(negedge clk);
            chk("back_pc", int'(pc), (4 - k > 0) ? 4 - k : 0);
        end

        // Clear during phase 2 of RUN
        run = 1;
        cyc(1 + 4 + 2);
        Clear = 1; run = 0;
        clk1();
        Clear = 0;
        @(negedge clk);
        chk("clr_pc", int'(pc), 0);
        chk("clr_phase", int'(phase), 0);
        chk("clr_state", int'(state), S_HLT);
        chk("clr_done", int'(instr_done), 0);

        // HALT opcode at end of instruction
        run = 1;
        cyc(4);
        halt_instr = 1;
        clk1();
        halt_instr = 0; run = 0;
        @(negedge clk);
        chk("hlt_pc", int'(pc), 0);
        chk("hlt_state", int'(state), S_HLT);
        chk("hlt_done", int'(instr_done), 1);

        // Mixed traffic against the model
        bp_en = 1; bp_addr = 10'd7;
        for (int i = 0; i < 600; i++) begin
            tick       = ($urandom_range(0, 3) != 0);
            run        = ($urandom_range(0, 7) != 0);
            step       = ($urandom_range(0, 11) == 0);
            back       = ($urandom_range(0, 11) == 0);
            jflag      = ($urandom_range(0, 5) == 0);
            enloop     = ($urandom_range(0, 1) == 1);
            halt_instr = ($urandom_range(0, 23) == 0);
            Clear      = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       jaddr = 10'h3FF;
                1:       jaddr = 10'h3FE;
                2:       jaddr = bp_addr;
                default: jaddr = 10'($urandom);
            endcase
            clk1();
        end
        Clear = 0; run = 0; step = 0; back = 0; jflag = 0; halt_instr = 0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
